// File: rtl/sub_bytes_arbiter.sv
// Two-requester arbiter in front of a shared combinational 128-bit Sub_Bytes,
// with a single valid/ready result register tagged by requester ID.
module sub_bytes_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [127:0] a_data,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [127:0] b_data,
  output logic [127:0] sbox_in,
  input  logic [127:0] sbox_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_id
);

  logic last_grant;
  logic grant_a;
  logic grant_b;
  logic can_accept;
  logic accept;

  // On a tie, round robin favours whoever did not win the last accepted transfer.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      if (RR_EN && !last_grant) grant_b = 1'b1;
      else                      grant_a = 1'b1;
    end else if (a_valid) begin
      grant_a = 1'b1;
    end else if (b_valid) begin
      grant_b = 1'b1;
    end
  end

  assign can_accept = !res_valid || res_ready;
  assign a_ready    = can_accept && grant_a;
  assign b_ready    = can_accept && grant_b;
  assign accept     = can_accept && (grant_a || grant_b);

  always_comb begin
    sbox_in = '0;
    if (grant_a)      sbox_in = a_data;
    else if (grant_b) sbox_in = b_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      res_valid  <= 1'b1;
      res_data   <= sbox_out;
      res_id     <= grant_b;
      last_grant <= grant_b;
    end else if (res_ready) begin
      res_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sub_bytes_arbiter.sv
// Bench for sub_bytes_arbiter: reference S-box, per-cycle vector tables and a
// result scoreboard, covering round-robin and fixed-priority instances.
module tb_sub_bytes_arbiter;

  localparam logic [127:0] D0  = '0;
  localparam logic [127:0] D53 = {16{8'h53}};
  localparam logic [127:0] DA  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] DB  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  typedef struct {
    logic         av;
    logic [127:0] ad;
    logic         bv;
    logic [127:0] bd;
    logic         rr;
    logic         ga;
    logic         gb;
  } vec_t;

  typedef struct {
    logic         id;
    logic [127:0] data;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         a_valid, b_valid, res_ready;
  logic [127:0] a_data, b_data;

  logic         a_ready, b_ready, res_valid, res_id;
  logic [127:0] sbox_in, sbox_out, res_data;
  logic         fp_a_ready, fp_b_ready, fp_res_valid, fp_res_id;
  logic [127:0] fp_sbox_in, fp_sbox_out, fp_res_data;

  logic         sel;
  logic         ck_a_ready, ck_b_ready, ck_res_valid, ck_res_id;
  logic [127:0] ck_sbox_in, ck_res_data;

  logic [7:0]   tab [256];
  logic         tab_done;
  res_t         sb [$];
  vec_t         tbl [$];
  int           checks;
  int           errors;

  sub_bytes_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .sbox_in(sbox_in), .sbox_out(sbox_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  sub_bytes_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(fp_a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(fp_b_ready), .b_data(b_data),
    .sbox_in(fp_sbox_in), .sbox_out(fp_sbox_out),
    .res_valid(fp_res_valid), .res_ready(res_ready),
    .res_data(fp_res_data), .res_id(fp_res_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [7:0] gmul(logic [7:0] x, logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic [7:0] a = x;
    logic [7:0] b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] sub128(logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = tab[d[i*8 +: 8]];
    return r;
  endfunction

  // Reference S-box: GF(2^8) inverse followed by the AES affine transform.
  initial begin
    tab_done = 1'b0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] r;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      tab[x] = s;
    end
    tab_done = 1'b1;
  end

  always @(sbox_in or tab_done)    sbox_out    = sub128(sbox_in);
  always @(fp_sbox_in or tab_done) fp_sbox_out = sub128(fp_sbox_in);

  always_comb begin
    ck_a_ready   = sel ? fp_a_ready   : a_ready;
    ck_b_ready   = sel ? fp_b_ready   : b_ready;
    ck_res_valid = sel ? fp_res_valid : res_valid;
    ck_res_id    = sel ? fp_res_id    : res_id;
    ck_sbox_in   = sel ? fp_sbox_in   : sbox_in;
    ck_res_data  = sel ? fp_res_data  : res_data;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic av, logic [127:0] ad, logic bv, logic [127:0] bd,
                              logic rr, logic ga, logic gb);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.rr = rr; v.ga = ga; v.gb = gb;
    return v;
  endfunction

  // Drive one cycle of stimulus, check at the falling edge, update the scoreboard.
  task automatic step(input vec_t v);
    logic   exp_valid;
    logic   ca;
    res_t   e;
    a_valid = v.av; a_data = v.ad; b_valid = v.bv; b_data = v.bd; res_ready = v.rr;
    @(negedge clk);
    exp_valid = (sb.size() != 0);
    check("res_valid", 128'(ck_res_valid), 128'(exp_valid));
    if (exp_valid) begin
      check("res_data", ck_res_data, sb[0].data);
      check("res_id", 128'(ck_res_id), 128'(sb[0].id));
    end
    ca = !exp_valid || v.rr;
    check("a_ready", 128'(ck_a_ready), 128'(v.ga && ca));
    check("b_ready", 128'(ck_b_ready), 128'(v.gb && ca));
    check("sbox_in", ck_sbox_in, v.ga ? v.ad : (v.gb ? v.bd : '0));
    if (exp_valid && v.rr) void'(sb.pop_front());
    if (ca && (v.ga || v.gb)) begin
      e.id   = v.gb;
      e.data = sub128(v.ga ? v.ad : v.bd);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0; res_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_res_valid"}, 128'(ck_res_valid), 128'(1'b0));
    check({tag, "_res_data"}, ck_res_data, '0);
    check({tag, "_res_id"}, 128'(ck_res_id), 128'(1'b0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel    = 1'b0;
    wait (tab_done);
    do_reset();
    check_reset_state("reset");

    // Directed first transfers against literal S-box values
    step(mk(1, D0, 0, '0, 1, 1, 0));
    check("a_zero_data", res_data, {16{8'h63}});
    check("a_zero_id", 128'(res_id), 128'(1'b0));
    step(mk(0, '0, 1, D53, 1, 0, 1));
    check("b_53_data", res_data, {16{8'hED}});
    check("b_53_id", 128'(res_id), 128'(1'b1));

    tbl.delete();
    tbl.push_back(mk(0, '0, 0, '0, 1, 0, 0));
    tbl.push_back(mk(0, '0, 0, '0, 1, 0, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(1, DA, 1, DB, 1, (i % 2) == 0, (i % 2) == 1));
    tbl.push_back(mk(1, D0, 0, '0, 1, 1, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, DA, 1, DB, 0, 0, 1));
    tbl.push_back(mk(1, DA, 1, DB, 1, 0, 1));
    tbl.push_back(mk(1, DA, 0, '0, 1, 1, 0));
    tbl.push_back(mk(0, '0, 0, '0, 1, 0, 0));
    tbl.push_back(mk(0, '0, 0, '0, 1, 0, 0));
    tbl.push_back(mk(1, D0, 0, '0, 1, 1, 0));
    tbl.push_back(mk(0, '0, 0, '0, 0, 0, 0));
    foreach (tbl[i]) step(tbl[i]);

    // Reset while FULL with an A request in flight; next tie must go to A
    rst_n = 1'b0;
    a_valid = 1'b1; a_data = DA; b_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_inputs();
    sb.delete();
    check_reset_state("midreset");
    step(mk(1, DA, 1, DB, 1, 1, 0));
    step(mk(0, '0, 0, '0, 1, 0, 0));
    step(mk(0, '0, 0, '0, 1, 0, 0));

    // Fixed-priority instance
    sel = 1'b1;
    do_reset();
    check_reset_state("fp_reset");
    tbl.delete();
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, DA, 1, DB, 1, 1, 0));
    tbl.push_back(mk(0, '0, 1, DB, 1, 0, 1));
    tbl.push_back(mk(0, '0, 0, '0, 1, 0, 0));
    tbl.push_back(mk(0, '0, 0, '0, 1, 0, 0));
    foreach (tbl[i]) step(tbl[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
